pong_game_ctrl: RTL

Match sequencer for the pong datapath. It gates the per-frame movement of the ball block and decides whether each wall approach is a paddle hit or a miss. It keeps both players' scores, runs the serve delay and respawn, and ends the match at a target score. It sits between the frame timing generator, the two paddle blocks and the ball block, and drives the ball's step enable and respawn strobe.

---
 rtl/pong_game_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: match sequencer for the pong datapath.
// Gates ball movement per frame, judges paddle hits against misses, keeps
// both scores, runs the serve delay/respawn and ends the match at WIN_SCORE.
module pong_game_ctrl #(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_DELAY = 60,
    parameter int LEFT_LIMIT  = 14,
    parameter int RIGHT_LIMIT = 626,
    parameter int PADDLE_H    = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       pause,
    input  logic [9:0] ball_x,
    input  logic [8:0] ball_y,
    input  logic [5:0] ball_w,
    input  logic       ball_dir_x,
    input  logic [8:0] paddle_l_y,
    input  logic [8:0] paddle_r_y,
    output logic       ball_step,
    output logic       ball_respawn,
    output logic       serve_dir,
    output logic       hit_l,
    output logic       hit_r,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [2:0] state,
    output logic       game_over
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SERVE  = 3'd1,
        PLAY   = 3'd2,
        SCORED = 3'd3,
        OVER   = 3'd4
    } state_t;

    localparam logic [3:0]  WIN_S = 4'(WIN_SCORE);
    localparam logic [7:0]  SD    = 8'(SERVE_DELAY);
    localparam logic [10:0] LL    = 11'(LEFT_LIMIT);
    localparam logic [10:0] RL    = 11'(RIGHT_LIMIT);
    localparam logic [10:0] PH    = 11'(PADDLE_H);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] score_l_q, score_l_d;
    logic [3:0] score_r_q, score_r_d;
    logic       serve_dir_q, serve_dir_d;
    logic       ball_step_q, ball_step_d;
    logic       ball_respawn_q, ball_respawn_d;
    logic       hit_l_q, hit_l_d;
    logic       hit_r_q, hit_r_d;
    logic       game_over_q, game_over_d;

    // Geometry: all sums widened to 11 bits so nothing truncates.
    logic [10:0] ball_bot, ball_top, ball_right, pl_top, pl_bot, pr_top, pr_bot;
    logic        ov_l, ov_r, wall_l, wall_r, live_tick;

    // Overlap and wall-approach conditions for the current ball position.
    always_comb begin
        ball_top   = {2'b00, ball_y};
        ball_bot   = {2'b00, ball_y} + {5'b00000, ball_w};
        ball_right = {1'b0, ball_x} + {5'b00000, ball_w};
        pl_top     = {2'b00, paddle_l_y};
        pl_bot     = {2'b00, paddle_l_y} + PH;
        pr_top     = {2'b00, paddle_r_y};
        pr_bot     = {2'b00, paddle_r_y} + PH;
        ov_l       = (ball_bot > pl_top) && (ball_top < pl_bot);
        ov_r       = (ball_bot > pr_top) && (ball_top < pr_bot);
        wall_l     = ball_dir_x && ({1'b0, ball_x} < LL);
        wall_r     = !ball_dir_x && (ball_right > RL);
        live_tick  = frame_tick && !pause;
    end

    // Next-state and registered-output logic of the match FSM.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        score_l_d      = score_l_q;
        score_r_d      = score_r_q;
        serve_dir_d    = serve_dir_q;
        ball_step_d    = 1'b0;
        ball_respawn_d = 1'b0;
        hit_l_d        = 1'b0;
        hit_r_d        = 1'b0;
        case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_d        = SERVE;
                    cnt_d          = 8'd0;
                    score_l_d      = 4'd0;
                    score_r_d      = 4'd0;
                    serve_dir_d    = 1'b0;
                    ball_respawn_d = 1'b1;
                end
            end
            SERVE: begin
                if (live_tick) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == SD) state_d = PLAY;
                end
            end
            PLAY: begin
                if (live_tick) begin
                    if (wall_l && !ov_l) begin
                        if (score_r_q < WIN_S) score_r_d = score_r_q + 4'd1;
                        serve_dir_d = 1'b1;
                        state_d     = SCORED;
                    end else if (wall_r && !ov_r) begin
                        if (score_l_q < WIN_S) score_l_d = score_l_q + 4'd1;
                        serve_dir_d = 1'b0;
                        state_d     = SCORED;
                    end else begin
                        // wall_l and wall_r are exclusive (they depend on ball_dir_x).
                        ball_step_d = 1'b1;
                        hit_l_d     = wall_l;
                        hit_r_d     = wall_r;
                    end
                end
            end
            SCORED: begin
                // serve_dir_q was just set to point at the side that conceded,
                // so it also identifies who scored: 1 = right player.
                if ((serve_dir_q ? score_r_q : score_l_q) == WIN_S) begin
                    state_d = OVER;
                end else begin
                    state_d        = SERVE;
                    cnt_d          = 8'd0;
                    ball_respawn_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        game_over_d = (state_d == OVER);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= 8'd0;
            score_l_q      <= 4'd0;
            score_r_q      <= 4'd0;
            serve_dir_q    <= 1'b0;
            ball_step_q    <= 1'b0;
            ball_respawn_q <= 1'b0;
            hit_l_q        <= 1'b0;
            hit_r_q        <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            score_l_q      <= score_l_d;
            score_r_q      <= score_r_d;
            serve_dir_q    <= serve_dir_d;
            ball_step_q    <= ball_step_d;
            ball_respawn_q <= ball_respawn_d;
            hit_l_q        <= hit_l_d;
            hit_r_q        <= hit_r_d;
            game_over_q    <= game_over_d;
        end
    end

    assign ball_step    = ball_step_q;
    assign ball_respawn = ball_respawn_q;
    assign serve_dir    = serve_dir_q;
    assign hit_l        = hit_l_q;
    assign hit_r        = hit_r_q;
    assign score_l      = score_l_q;
    assign score_r      = score_r_q;
    assign state        = state_q;
    assign game_over    = game_over_q;

endmodule
